// File: rtl/fp_to_int_converter_seq.sv
// Iterative floating-point to integer converter: one shift per cycle under a small FSM,
// with truncate / round-to-nearest-even, signed / unsigned results and saturation flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for an operand; in_ready=1
// S_LOAD  | classify operand, resolve specials, load magnitude + shift count
// S_SHIFT | shift one bit per cycle; right shifts collect guard/sticky
// S_ROUND | apply rounding, range check, sign, write result
// S_DONE  | hold result with out_valid=1 until out_ready
module fp_to_int_converter_seq #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   parameter int INT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+MAN_W:0]     in_fp,
   input  logic                     round_mode,
   input  logic                     signed_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [INT_W-1:0]         out_int,
   output logic                     overflow,
   output logic                     inexact,
   output logic                     inf,
   output logic                     nan,
   output logic                     subnormal,
   output logic                     zero,
   output logic                     negative
);

   localparam int FP_W  = 1 + EXP_W + MAN_W;
   localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
   localparam int CNT_W = $clog2(INT_W + MAN_W + 2);
   localparam logic [INT_W:0] HALF = {2'b01, {(INT_W-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_ROUND, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [FP_W-1:0]    fp_q, fp_d;
   logic               rm_q, rm_d;
   logic               sm_q, sm_d;
   logic [INT_W-1:0]   work_q, work_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               left_q, left_d;
   logic               guard_q, guard_d;
   logic               sticky_q, sticky_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [INT_W-1:0]   out_int_q, out_int_d;
   logic               ovf_q, ovf_d;
   logic               inx_q, inx_d;
   logic               inf_q, inf_d;
   logic               nan_q, nan_d;
   logic               sub_q, sub_d;
   logic               zero_q, zero_d;
   logic               neg_q, neg_d;

   logic               sign_c;
   logic [EXP_W-1:0]   exp_c;
   logic [MAN_W-1:0]   man_c;
   int                 e_c;
   logic [INT_W-1:0]   sat_pos_c, sat_neg_c, sat_sign_c;
   logic               inc_c;
   logic [INT_W:0]     mag_c;
   logic               in_range_c;
   logic               wr_res_c;
   logic [INT_W-1:0]   res_c;
   logic               ovf_c, inx_c, inf_c, nan_c, sub_c;

   always_comb begin
      sign_c = fp_q[FP_W-1];
      exp_c  = fp_q[FP_W-2 -: EXP_W];
      man_c  = fp_q[MAN_W-1:0];
      e_c    = int'(exp_c) - BIAS;

      sat_pos_c  = sm_q ? {1'b0, {(INT_W-1){1'b1}}} : {INT_W{1'b1}};
      sat_neg_c  = sm_q ? {1'b1, {(INT_W-1){1'b0}}} : {INT_W{1'b0}};
      sat_sign_c = sign_c ? sat_neg_c : sat_pos_c;

      inc_c = rm_q & guard_q & (sticky_q | work_q[0]);
      mag_c = {1'b0, work_q} + {{INT_W{1'b0}}, inc_c};
      if (sm_q)
         in_range_c = sign_c ? (mag_c <= HALF) : (mag_c < HALF);
      else
         in_range_c = sign_c ? (mag_c == '0) : !mag_c[INT_W];

      state_d     = state_q;
      fp_d        = fp_q;
      rm_d        = rm_q;
      sm_d        = sm_q;
      work_d      = work_q;
      cnt_d       = cnt_q;
      left_d      = left_q;
      guard_d     = guard_q;
      sticky_d    = sticky_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_int_d   = out_int_q;
      ovf_d       = ovf_q;
      inx_d       = inx_q;
      inf_d       = inf_q;
      nan_d       = nan_q;
      sub_d       = sub_q;
      zero_d      = zero_q;
      neg_d       = neg_q;

      wr_res_c = 1'b0;
      res_c    = '0;
      ovf_c    = 1'b0;
      inx_c    = 1'b0;
      inf_c    = 1'b0;
      nan_c    = 1'b0;
      sub_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready_d = 1'b1;
            if (in_valid && in_ready_q) begin
               fp_d       = in_fp;
               rm_d       = round_mode;
               sm_d       = signed_mode;
               in_ready_d = 1'b0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            work_d   = INT_W'({1'b1, man_c});
            guard_d  = 1'b0;
            sticky_d = 1'b0;
            if (exp_c == '1) begin
               wr_res_c = 1'b1;
               ovf_c    = 1'b1;
               if (man_c != '0) begin
                  nan_c = 1'b1;
                  res_c = sat_pos_c;
               end else begin
                  inf_c = 1'b1;
                  res_c = sat_sign_c;
               end
            end else if (exp_c == '0) begin
               wr_res_c = 1'b1;
               sub_c    = (man_c != '0);
               inx_c    = (man_c != '0);
            end else if (e_c >= INT_W) begin
               wr_res_c = 1'b1;
               ovf_c    = 1'b1;
               res_c    = sat_sign_c;
            end else if (e_c <= -2) begin
               wr_res_c = 1'b1;
               inx_c    = 1'b1;
            end else if (e_c > MAN_W) begin
               left_d  = 1'b1;
               cnt_d   = CNT_W'(e_c - MAN_W);
               state_d = S_SHIFT;
            end else begin
               left_d  = 1'b0;
               cnt_d   = CNT_W'(MAN_W - e_c);
               state_d = (e_c == MAN_W) ? S_ROUND : S_SHIFT;
            end
            if (wr_res_c) begin
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_SHIFT: begin
            if (left_q) begin
               work_d = work_q << 1;
            end else begin
               work_d   = work_q >> 1;
               guard_d  = work_q[0];
               sticky_d = sticky_q | guard_q;
            end
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1))
               state_d = S_ROUND;
         end
         S_ROUND: begin
            wr_res_c = 1'b1;
            inx_c    = guard_q | sticky_q;
            if (!in_range_c) begin
               ovf_c = 1'b1;
               res_c = sat_sign_c;
            end else if (sm_q && sign_c) begin
               res_c = -mag_c[INT_W-1:0];
            end else begin
               res_c = mag_c[INT_W-1:0];
            end
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase

      // zero/negative always follow the integer actually presented
      if (wr_res_c) begin
         out_int_d = res_c;
         ovf_d     = ovf_c;
         inx_d     = inx_c;
         inf_d     = inf_c;
         nan_d     = nan_c;
         sub_d     = sub_c;
         zero_d    = (res_c == '0);
         neg_d     = sm_q & res_c[INT_W-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         fp_q        <= '0;
         rm_q        <= 1'b0;
         sm_q        <= 1'b0;
         work_q      <= '0;
         cnt_q       <= '0;
         left_q      <= 1'b0;
         guard_q     <= 1'b0;
         sticky_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_int_q   <= '0;
         ovf_q       <= 1'b0;
         inx_q       <= 1'b0;
         inf_q       <= 1'b0;
         nan_q       <= 1'b0;
         sub_q       <= 1'b0;
         zero_q      <= 1'b0;
         neg_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fp_q        <= fp_d;
         rm_q        <= rm_d;
         sm_q        <= sm_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         left_q      <= left_d;
         guard_q     <= guard_d;
         sticky_q    <= sticky_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_int_q   <= out_int_d;
         ovf_q       <= ovf_d;
         inx_q       <= inx_d;
         inf_q       <= inf_d;
         nan_q       <= nan_d;
         sub_q       <= sub_d;
         zero_q      <= zero_d;
         neg_q       <= neg_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_int   = out_int_q;
   assign overflow  = ovf_q;
   assign inexact   = inx_q;
   assign inf       = inf_q;
   assign nan       = nan_q;
   assign subnormal = sub_q;
   assign zero      = zero_q;
   assign negative  = neg_q;

endmodule

// File: tb/tb_fp_to_int_converter_seq.sv
// Scoreboard bench for fp_to_int_converter_seq (half precision -> 16-bit integer).
// Flag vectors are ordered {overflow, inexact, inf, nan, subnormal, zero, negative}.
module tb_fp_to_int_converter_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_fp;
   logic        round_mode;
   logic        signed_mode;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_int;
   logic        overflow, inexact, inf, nan, subnormal, zero, negative;

   fp_to_int_converter_seq #(.EXP_W(5), .MAN_W(10), .INT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_fp      (in_fp),
      .round_mode (round_mode),
      .signed_mode(signed_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_int    (out_int),
      .overflow   (overflow),
      .inexact    (inexact),
      .inf        (inf),
      .nan        (nan),
      .subnormal  (subnormal),
      .zero       (zero),
      .negative   (negative)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] oi;
      logic [6:0]  fl;
      int          lat;
      int          t_acc;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic logic [6:0] flags_now();
      return {overflow, inexact, inf, nan, subnormal, zero, negative};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor: compare on the first cycle each result is presented
   initial begin
      bit   seen;
      exp_t e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            seen = 1'b0;
         end else if (out_valid && !seen) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
               check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("out_int", 32'(out_int), 32'(e.oi));
               check("flags",   32'(flags_now()), 32'(e.fl));
               check("latency", 32'(cyc - e.t_acc + 1), 32'(e.lat));
            end
         end else if (!out_valid) begin
            seen = 1'b0;
         end
      end
   end

   task automatic issue(input logic [15:0] fp, input logic rm, input logic sm,
                        input logic [15:0] oi, input logic [6:0] fl, input int lat,
                        input bit push, output int waited);
      int w;
      @(negedge clk);
      in_fp       = fp;
      round_mode  = rm;
      signed_mode = sm;
      in_valid    = 1'b1;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      waited = w;
      if (!in_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (push) sb_q.push_back('{oi, fl, lat, cyc});
      end
   endtask

   task automatic wait_done();
      int w;
      w = 0;
      while ((sb_q.size() != 0 || out_valid) && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("done_within_budget", 32'(sb_q.size() == 0 && !out_valid), 32'd1);
   endtask

   task automatic run(input logic [15:0] fp, input logic rm, input logic sm,
                      input logic [15:0] oi, input logic [6:0] fl, input int lat);
      int w;
      issue(fp, rm, sm, oi, fl, lat, 1'b1, w);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_fp       = '0;
      round_mode  = 1'b0;
      signed_mode = 1'b0;
      out_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready",  32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_int",   32'(out_int), 32'd0);
      check("reset_flags",     32'(flags_now()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //   fp        rm    sm    out_int   flags        latency
      run(16'h4900, 1'b0, 1'b1, 16'h000A, 7'b0000000, 10);
      run(16'h3E00, 1'b0, 1'b1, 16'h0001, 7'b0100000, 13);
      run(16'h3E00, 1'b1, 1'b1, 16'h0002, 7'b0100000, 13);
      run(16'h3800, 1'b1, 1'b1, 16'h0000, 7'b0100010, 14);
      run(16'h3A00, 1'b1, 1'b1, 16'h0001, 7'b0100000, 14);
      run(16'hBE00, 1'b1, 1'b1, 16'hFFFE, 7'b0100001, 13);
      run(16'h7C00, 1'b0, 1'b1, 16'h7FFF, 7'b1010000, 2);
      run(16'hFC00, 1'b0, 1'b1, 16'h8000, 7'b1010001, 2);
      run(16'h7E01, 1'b0, 1'b1, 16'h7FFF, 7'b1001000, 2);
      run(16'h0001, 1'b0, 1'b1, 16'h0000, 7'b0100110, 2);
      run(16'h7800, 1'b0, 1'b1, 16'h7FFF, 7'b1000000, 8);
      run(16'h7800, 1'b0, 1'b0, 16'h8000, 7'b0000000, 8);
      run(16'hF800, 1'b0, 1'b1, 16'h8000, 7'b0000001, 8);
      run(16'hBC00, 1'b0, 1'b0, 16'h0000, 7'b1000010, 13);
      run(16'h3000, 1'b1, 1'b1, 16'h0000, 7'b0100010, 2);
      run(16'h8000, 1'b0, 1'b1, 16'h0000, 7'b0000010, 2);

      // backpressure: result must hold while out_ready is low
      out_ready = 1'b0;
      issue(16'h6400, 1'b0, 1'b1, 16'h0400, 7'b0000000, 3, 1'b1, w);
      w = 0;
      while (!out_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("hold_reached_valid", 32'(out_valid), 32'd1);
      repeat (5) begin
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_out_int",   32'(out_int), 32'h0400);
         check("hold_in_ready",  32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_out_valid", 32'(out_valid), 32'd0);
      check("release_in_ready",  32'(in_ready), 32'd1);
      issue(16'h4900, 1'b0, 1'b1, 16'h000A, 7'b0000000, 10, 1'b1, w);
      check("accept_after_release_wait", 32'(w), 32'd0);
      wait_done();

      // reset in the middle of a shift sequence aborts without emitting
      issue(16'h4900, 1'b0, 1'b1, 16'h0000, 7'b0000000, 0, 1'b0, w);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midreset_in_ready",  32'(in_ready), 32'd1);
      check("midreset_out_valid", 32'(out_valid), 32'd0);
      check("midreset_out_int",   32'(out_int), 32'd0);
      check("midreset_flags",     32'(flags_now()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(16'h3C00, 1'b0, 1'b1, 16'h0001, 7'b0000000, 13);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_to_int_converter_seq.md
Name: fp_to_int_converter_seq

Overview:
- Multi-cycle, parametrised floating-point to integer converter for the ALU datapath.
- Generalises the combinational half-precision converter in four ways:
  - configurable exponent, mantissa and integer widths;
  - valid/ready handshakes on input and output;
  - selectable truncate or round-to-nearest-even;
  - selectable signed or unsigned result, plus an inexact flag.
- Uses an iterative 1-bit-per-cycle shifter under an FSM, trading latency for area.

Parameters:
- EXP_W, 5, exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 10, stored mantissa width; implicit leading 1 for normals.
- INT_W, 16, result integer width. Legal when INT_W > MAN_W+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  operand valid.
- in_ready  out  1  converter idle and able to accept.
- in_fp  in  1+EXP_W+MAN_W  operand: {sign, exponent, mantissa}.
- round_mode  in  1  0 = truncate toward zero, 1 = round-to-nearest-even.
- signed_mode  in  1  1 = two's-complement result, 0 = unsigned result.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- out_int  out  INT_W  converted integer.
- overflow  out  1  result saturated, or input is inf/NaN.
- inexact  out  1  nonzero fraction bits were discarded.
- inf  out  1  input is ±infinity.
- nan  out  1  input is NaN.
- subnormal  out  1  input is subnormal.
- zero  out  1  out_int == 0.
- negative  out  1  out_int MSB (signed_mode=1 only; otherwise 0).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; in_ready=1; out_valid=0.
  - out_int=0 and all flags=0.
  - Reset dominates in every state and aborts any operation in progress; nothing is emitted for it.
- FSM states: IDLE, LOAD, SHIFT, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (edge T): capture in_fp, round_mode and signed_mode; go to LOAD.
  - in_ready=0 in every state other than IDLE.
- LOAD (one cycle): classify the operand and compute unbiased exponent e = exp - bias.
  - Special cases go straight to DONE:
    - Zero: result 0.
    - Subnormal: result 0; subnormal=1, inexact=1.
    - ±inf: result saturates by sign; inf=1, overflow=1.
    - NaN: result = max positive; nan=1, overflow=1.
    - e ≥ INT_W: saturate by sign; overflow=1.
    - e ≤ -2: result 0; inexact=1.
  - Otherwise load the working register with {1, mantissa}. Set shift count n = |e - MAN_W| and direction left if e > MAN_W, else right. Go to SHIFT if n>0, else ROUND.
- SHIFT:
  - One bit per cycle; decrement n; go to ROUND when n reaches 0.
  - Right shifts maintain a guard bit (last bit shifted out) and a sticky bit (OR of all earlier bits shifted out).
  - Left shifts fill with 0; guard and sticky stay 0.
- ROUND (one cycle):
  - inexact = guard|sticky.
  - RNE increments the magnitude when guard & (sticky | lsb). Truncate never increments.
  - Range check on the rounded magnitude M:
    - signed: M ≤ 2^(INT_W-1)-1, or M = 2^(INT_W-1) when negative.
    - unsigned: M ≤ 2^INT_W-1, and no negative nonzero M.
  - Out of range: saturate. Signed saturates by sign to max positive or min negative. Unsigned: negative saturates to 0, positive to all-ones. Set overflow=1.
  - In range: out_int = M, two's-complemented if signed and negative.
  - Go to DONE.
- DONE:
  - out_valid=1; out_int and all flags stable.
  - On out_ready: out_valid=0 at the next edge; return to IDLE. The next operand may be accepted at the first IDLE cycle.
  - While out_ready=0, hold everything indefinitely.
- Latency from accept edge T:
  - special or early-out: out_valid high at T+2;
  - normal: out_valid high at T+3+n.
- Throughput: one operation in flight; no pipelining.
- Flags zero and negative derive from the final out_int. inf, nan and subnormal are mutually exclusive.

Test Plan:
- 0x4900 (10.0), truncate, signed: out_valid high at T+10 (n=7) → out_int=10, inexact=0, flags clear.
- 0x3E00 (1.5) → truncate gives 1 with inexact=1; RNE gives 2. 0x3800 (0.5) RNE → 0, inexact=1. 0x3A00 (0.75) RNE → 1. 0xBE00 (-1.5) RNE signed → 0xFFFE, negative=1.
- 0x7C00 → 0x7FFF with inf=1 and overflow=1, at T+2. 0xFC00 → 0x8000. 0x7E01 → 0x7FFF with nan=1 and overflow=1. 0x0001 → 0 with subnormal=1.
- 0x7800 (32768): signed → 0x7FFF, overflow=1; unsigned → 0x8000, overflow=0. 0xF800 signed → 0x8000, overflow=0. 0xBC00 (-1.0) unsigned → 0, overflow=1.
- 0x6400 (1024, n=0): out_valid high at T+3. Hold out_ready=0 for 5 cycles → out_valid and out_int stable, in_ready=0. Release out_ready → next operand accepted in the following IDLE cycle.
- Assert rst_n=0 mid-SHIFT while converting 0x4900 → next edge: IDLE, in_ready=1, out_valid=0, flags 0. Then a fresh 0x3C00 → out_int=1.
